// File: rtl/visitor_dir_detector_pkg.sv
// Shared definitions for the visitor direction detector: FSM state encoding
// and the {da, db} sensor code names used by the crossing decoder.
package visitor_dir_detector_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_IN_A   = 3'd1,
        ST_IN_AB  = 3'd2,
        ST_IN_B   = 3'd3,
        ST_OUT_B  = 3'd4,
        ST_OUT_BA = 3'd5,
        ST_OUT_A  = 3'd6
    } state_t;

    // Codes are {da, db}: bit 1 = outer sensor, bit 0 = inner sensor.
    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_B    = 2'b01;
    localparam logic [1:0] CODE_A    = 2'b10;
    localparam logic [1:0] CODE_AB   = 2'b11;

endpackage

// File: rtl/visitor_dir_detector_debounce.sv
// Two-flop synchronizer followed by a stability counter: the level follows the
// synced input only after DEB_CYCLES consecutive differing samples.
module sensor_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Any sample agreeing with the current level restarts the run.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/visitor_dir_detector.sv
// Debounces the outer/inner IR sensors, decodes crossing order into entry/exit
// strobes, and keeps a saturating occupancy count with a stale-sequence timeout.
import visitor_dir_detector_pkg::*;

module visitor_dir_detector #(
    parameter int DEB_CYCLES     = 4,
    parameter int CNT_W          = 8,
    parameter int MAX_COUNT      = 99,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sens_a_raw,
    input  logic             sens_b_raw,
    output logic             entry_pulse,
    output logic             exit_pulse,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             seq_abort
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);

    logic [1:0]       w_raw;
    logic [1:0]       w_code;
    logic             w_change;
    logic             w_timeout;
    logic             w_entry;
    logic             w_exit;
    state_t           w_state_next;

    state_t           r_state;
    logic [1:0]       r_code_prev;
    logic [TMR_W-1:0] r_timer;
    logic             r_entry;
    logic             r_exit;
    logic             r_abort;
    logic [CNT_W-1:0] r_count;

    assign w_raw = {sens_a_raw, sens_b_raw};

    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
        sensor_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_raw   (w_raw[gi]),
            .o_level (w_code[gi])
        );
    end

    assign w_change  = (w_code != r_code_prev);
    // A level change in the same cycle keeps the sequence alive.
    assign w_timeout = (r_state != ST_IDLE) && !w_change && (r_timer == TMR_LAST);

    always_comb begin
        w_state_next = r_state;
        w_entry      = 1'b0;
        w_exit       = 1'b0;
        if (w_timeout) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_code == CODE_A)      w_state_next = ST_IN_A;
                    else if (w_code == CODE_B) w_state_next = ST_OUT_B;
                end
                ST_IN_A: begin
                    if (w_code == CODE_AB)        w_state_next = ST_IN_AB;
                    else if (w_code == CODE_B)    w_state_next = ST_IN_B;
                    else if (w_code == CODE_NONE) w_state_next = ST_IDLE;
                end
                ST_IN_AB: begin
                    if (w_code == CODE_B)         w_state_next = ST_IN_B;
                    else if (w_code == CODE_A)    w_state_next = ST_IN_A;
                    else if (w_code == CODE_NONE) w_state_next = ST_IDLE;
                end
                ST_IN_B: begin
                    if (w_code == CODE_NONE) begin
                        w_state_next = ST_IDLE;
                        w_entry      = 1'b1;
                    end else if (w_code == CODE_AB) begin
                        w_state_next = ST_IN_AB;
                    end else if (w_code == CODE_A) begin
                        w_state_next = ST_IN_A;
                    end
                end
                ST_OUT_B: begin
                    if (w_code == CODE_AB)        w_state_next = ST_OUT_BA;
                    else if (w_code == CODE_A)    w_state_next = ST_OUT_A;
                    else if (w_code == CODE_NONE) w_state_next = ST_IDLE;
                end
                ST_OUT_BA: begin
                    if (w_code == CODE_A)         w_state_next = ST_OUT_A;
                    else if (w_code == CODE_B)    w_state_next = ST_OUT_B;
                    else if (w_code == CODE_NONE) w_state_next = ST_IDLE;
                end
                ST_OUT_A: begin
                    if (w_code == CODE_NONE) begin
                        w_state_next = ST_IDLE;
                        w_exit       = 1'b1;
                    end else if (w_code == CODE_AB) begin
                        w_state_next = ST_OUT_BA;
                    end else if (w_code == CODE_B) begin
                        w_state_next = ST_OUT_B;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_code_prev <= CODE_NONE;
            r_timer     <= '0;
            r_entry     <= 1'b0;
            r_exit      <= 1'b0;
            r_abort     <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_code_prev <= w_code;
            r_entry     <= w_entry;
            r_exit      <= w_exit;
            r_abort     <= w_timeout;
            if ((r_state == ST_IDLE) || w_change || w_timeout) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
            // Saturate at both ends; the strobe still fires when held.
            if (w_entry && (r_count != CNT_MAX)) begin
                r_count <= r_count + 1'b1;
            end else if (w_exit && (r_count != '0)) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign entry_pulse = r_entry;
    assign exit_pulse  = r_exit;
    assign seq_abort   = r_abort;
    assign count       = r_count;
    assign full        = (r_count == CNT_MAX);
    assign empty       = (r_count == '0);

endmodule

// File: tb/tb_visitor_dir_detector.sv
// Randomized scenario bench for visitor_dir_detector, checked against a
// crossing-order reference model kept inside the bench.
module tb_visitor_dir_detector;

    localparam int DEB  = 4;
    localparam int CW   = 8;
    localparam int MAXC = 3;
    localparam int TO   = 50;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_raw;
    logic          b_raw;
    logic          entry_pulse;
    logic          exit_pulse;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          seq_abort;

    visitor_dir_detector #(
        .DEB_CYCLES     (DEB),
        .CNT_W          (CW),
        .MAX_COUNT      (MAXC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sens_a_raw  (a_raw),
        .sens_b_raw  (b_raw),
        .entry_pulse (entry_pulse),
        .exit_pulse  (exit_pulse),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .seq_abort   (seq_abort)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: synchronizer delay line, sample-window debounce, and a
    // crossing tracker holding only the direction and the last occupied code.
    bit           m_s1a, m_s2a, m_s1b, m_s2b;
    bit [DEB-1:0] m_ha, m_hb;
    bit           m_da, m_db;
    bit [1:0]     m_prev;
    int           m_dir;          // 0 none, 1 entering, 2 leaving
    bit [1:0]     m_last;
    int           m_timer;
    int           m_count;
    bit           m_entry, m_exit, m_abort;

    int    obs_entry = 0, obs_exit = 0, obs_abort = 0;
    int    mdl_entry = 0, mdl_exit = 0, mdl_abort = 0;
    int    cyc_bad = 0;
    string first_bad = "";

    function automatic bit deb_next(input bit [DEB-1:0] h, input bit lvl);
        // The level flips once the whole window disagrees with it.
        if (lvl) return !(h == '0);
        return &h;
    endfunction

    task automatic model_reset();
        m_s1a = 0; m_s2a = 0; m_s1b = 0; m_s2b = 0;
        m_ha = '0; m_hb = '0; m_da = 0; m_db = 0;
        m_prev = 2'b00; m_dir = 0; m_last = 2'b00; m_timer = 0; m_count = 0;
        m_entry = 0; m_exit = 0; m_abort = 0;
    endtask

    task automatic model_step();
        bit [1:0] code;
        bit       change;
        bit       timeout;
        code    = {m_da, m_db};
        change  = (code != m_prev);
        timeout = (m_dir != 0) && !change && (m_timer == TO - 1);
        if (m_dir == 0 || change || timeout) m_timer = 0;
        else                                 m_timer++;
        m_entry = 0; m_exit = 0; m_abort = timeout;
        if (timeout) begin
            m_dir = 0;
        end else if (m_dir == 0) begin
            if (code == 2'b10)      begin m_dir = 1; m_last = code; end
            else if (code == 2'b01) begin m_dir = 2; m_last = code; end
        end else if (code == 2'b00) begin
            if (m_dir == 1 && m_last == 2'b01) m_entry = 1;
            if (m_dir == 2 && m_last == 2'b10) m_exit  = 1;
            m_dir = 0;
        end else begin
            m_last = code;
        end
        if (m_entry && m_count < MAXC) m_count++;
        if (m_exit && m_count > 0)     m_count--;
        m_prev = code;
        m_ha = {m_ha[DEB-2:0], m_s2a}; m_da = deb_next(m_ha, m_da);
        m_hb = {m_hb[DEB-2:0], m_s2b}; m_db = deb_next(m_hb, m_db);
        m_s2a = m_s1a; m_s1a = a_raw;
        m_s2b = m_s1b; m_s1b = b_raw;
    endtask

    task automatic tick();
        if (rst_n) model_step();
        @(posedge clk);
        #1;
        obs_entry += int'(entry_pulse); obs_exit += int'(exit_pulse); obs_abort += int'(seq_abort);
        mdl_entry += int'(m_entry);     mdl_exit += int'(m_exit);     mdl_abort += int'(m_abort);
        if ({entry_pulse, exit_pulse, seq_abort, full, empty} !==
                {m_entry, m_exit, m_abort, (m_count == MAXC), (m_count == 0)} ||
            count !== CW'(m_count)) begin
            cyc_bad++;
            if (first_bad == "")
                first_bad = $sformatf("t=%0t got ent/ex/ab/full/empty/count=%b%b%b%b%b/%0d need %b%b%b%b%b/%0d",
                    $time, entry_pulse, exit_pulse, seq_abort, full, empty, count,
                    m_entry, m_exit, m_abort, (m_count == MAXC), (m_count == 0), m_count);
        end
    endtask

    task automatic hold(input bit a, input bit b, input int n);
        a_raw = a; b_raw = b;
        repeat (n) tick();
    endtask

    function automatic int dur();
        return $urandom_range(8, 14);
    endfunction

    task automatic do_entry();
        hold(1, 0, dur()); hold(1, 1, dur()); hold(0, 1, dur()); hold(0, 0, dur());
    endtask

    task automatic do_exit();
        hold(0, 1, dur()); hold(1, 1, dur()); hold(1, 0, dur()); hold(0, 0, dur());
    endtask

    task automatic test_reset();
        rst_n = 0; a_raw = 0; b_raw = 0;
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d need 0", count); end
        n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got empty=%b full=%b need 1 0", empty, full); end
        n_cmp++; if ({entry_pulse, exit_pulse, seq_abort} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b need 000", {entry_pulse, exit_pulse, seq_abort}); end
        rst_n = 1;
        hold(0, 0, 5);
        $display("test_reset: count=%0d empty=%b", count, empty);
    endtask

    task automatic test_entry();
        int e0 = obs_entry; int c0 = cyc_bad;
        do_entry();
        n_cmp++; if (cyc_bad != c0) begin n_fail++; $display("FAIL entry_cycles: %0d bad cycles, first %s", cyc_bad - c0, first_bad); end
        n_cmp++; if (obs_entry - e0 != 1) begin n_fail++; $display("FAIL entry_pulses: got %0d need 1", obs_entry - e0); end
        n_cmp++; if (count !== 8'd1 || empty !== 1'b0) begin n_fail++; $display("FAIL entry_count: got %0d empty=%b need 1 empty=0", count, empty); end
        $display("test_entry: pulses=%0d count=%0d", obs_entry - e0, count);
    endtask

    task automatic test_exit();
        int x0 = obs_exit; int c0 = cyc_bad;
        do_exit();
        n_cmp++; if (cyc_bad != c0) begin n_fail++; $display("FAIL exit_cycles: %0d bad cycles, first %s", cyc_bad - c0, first_bad); end
        n_cmp++; if (obs_exit - x0 != 1) begin n_fail++; $display("FAIL exit_pulses: got %0d need 1", obs_exit - x0); end
        n_cmp++; if (count !== 8'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL exit_count: got %0d empty=%b need 0 empty=1", count, empty); end
        $display("test_exit: pulses=%0d count=%0d", obs_exit - x0, count);
    endtask

    task automatic test_bounce();
        int p0 = obs_entry + obs_exit + obs_abort; int c0 = cyc_bad;
        repeat (5) begin hold(1, 0, 2); hold(0, 0, 2); end
        hold(0, 0, TO + 10);
        n_cmp++; if (cyc_bad != c0) begin n_fail++; $display("FAIL bounce_cycles: %0d bad cycles, first %s", cyc_bad - c0, first_bad); end
        n_cmp++; if (obs_entry + obs_exit + obs_abort != p0) begin n_fail++; $display("FAIL bounce_pulses: got %0d pulses need 0", obs_entry + obs_exit + obs_abort - p0); end
        $display("test_bounce: pulses=%0d count=%0d", obs_entry + obs_exit + obs_abort - p0, count);
    endtask

    task automatic test_saturation();
        int e0 = obs_entry; int x0 = obs_exit; int c0 = cyc_bad;
        repeat (5) do_entry();
        n_cmp++; if (obs_entry - e0 != 5) begin n_fail++; $display("FAIL sat_entries: got %0d need 5", obs_entry - e0); end
        n_cmp++; if (count !== 8'd3 || full !== 1'b1) begin n_fail++; $display("FAIL sat_full: got %0d full=%b need 3 full=1", count, full); end
        repeat (4) do_exit();
        n_cmp++; if (obs_exit - x0 != 4) begin n_fail++; $display("FAIL sat_exits: got %0d need 4", obs_exit - x0); end
        n_cmp++; if (count !== 8'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL sat_empty: got %0d empty=%b need 0 empty=1", count, empty); end
        n_cmp++; if (cyc_bad != c0) begin n_fail++; $display("FAIL sat_cycles: %0d bad cycles, first %s", cyc_bad - c0, first_bad); end
        $display("test_saturation: entries=%0d exits=%0d count=%0d", obs_entry - e0, obs_exit - x0, count);
    endtask

    task automatic test_backout();
        int p0 = obs_entry + obs_exit; int a0 = obs_abort; int c0 = cyc_bad;
        hold(1, 0, dur()); hold(1, 1, dur()); hold(1, 0, dur()); hold(0, 0, dur());
        n_cmp++; if (obs_entry + obs_exit != p0 || count !== 8'd0) begin n_fail++; $display("FAIL backout_noevent: got %0d pulses count=%0d need 0 0", obs_entry + obs_exit - p0, count); end
        hold(1, 0, 60); hold(0, 0, 20);
        n_cmp++; if (obs_abort - a0 != 1) begin n_fail++; $display("FAIL backout_abort: got %0d aborts need 1", obs_abort - a0); end
        n_cmp++; if (obs_entry + obs_exit != p0 || count !== 8'd0) begin n_fail++; $display("FAIL backout_count: got %0d pulses count=%0d need 0 0", obs_entry + obs_exit - p0, count); end
        n_cmp++; if (cyc_bad != c0) begin n_fail++; $display("FAIL backout_cycles: %0d bad cycles, first %s", cyc_bad - c0, first_bad); end
        $display("test_backout: aborts=%0d count=%0d", obs_abort - a0, count);
    endtask

    task automatic test_async_reset();
        int e0; int c0;
        repeat (2) do_entry();
        n_cmp++; if (count !== 8'd2) begin n_fail++; $display("FAIL arst_pre_count: got %0d need 2", count); end
        hold(1, 0, dur()); hold(1, 1, dur());
        e0 = obs_entry; c0 = cyc_bad;
        #2;
        rst_n = 0;
        model_reset();
        #1;
        n_cmp++; if (count !== 8'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL arst_count: got %0d empty=%b need 0 empty=1", count, empty); end
        n_cmp++; if ({entry_pulse, exit_pulse, seq_abort} !== 3'b000) begin n_fail++; $display("FAIL arst_pulses: got %b need 000", {entry_pulse, exit_pulse, seq_abort}); end
        repeat (3) tick();
        rst_n = 1;
        hold(1, 1, dur()); hold(0, 1, dur()); hold(0, 0, dur());
        n_cmp++; if (obs_entry != e0) begin n_fail++; $display("FAIL arst_no_entry: got %0d entries need 0", obs_entry - e0); end
        n_cmp++; if (cyc_bad != c0) begin n_fail++; $display("FAIL arst_cycles: %0d bad cycles, first %s", cyc_bad - c0, first_bad); end
        $display("test_async_reset: entries_after=%0d count=%0d", obs_entry - e0, count);
    endtask

    task automatic test_random();
        int e0 = obs_entry; int x0 = obs_exit; int a0 = obs_abort;
        int me0 = mdl_entry; int mx0 = mdl_exit; int ma0 = mdl_abort; int c0 = cyc_bad;
        for (int i = 0; i < 40; i++) begin
            int code = $urandom_range(0, 3);
            int n = ($urandom_range(0, 7) == 0) ? TO + 5 : $urandom_range(1, 16);
            hold(code[1], code[0], n);
        end
        hold(0, 0, TO + 10);
        n_cmp++; if (cyc_bad != c0) begin n_fail++; $display("FAIL rand_cycles: %0d bad cycles, first %s", cyc_bad - c0, first_bad); end
        n_cmp++; if (obs_entry - e0 != mdl_entry - me0) begin n_fail++; $display("FAIL rand_entries: got %0d need %0d", obs_entry - e0, mdl_entry - me0); end
        n_cmp++; if (obs_exit - x0 != mdl_exit - mx0) begin n_fail++; $display("FAIL rand_exits: got %0d need %0d", obs_exit - x0, mdl_exit - mx0); end
        n_cmp++; if (obs_abort - a0 != mdl_abort - ma0) begin n_fail++; $display("FAIL rand_aborts: got %0d need %0d", obs_abort - a0, mdl_abort - ma0); end
        n_cmp++; if (count !== CW'(m_count)) begin n_fail++; $display("FAIL rand_count: got %0d need %0d", count, m_count); end
        $display("test_random: entries=%0d exits=%0d aborts=%0d count=%0d",
                 obs_entry - e0, obs_exit - x0, obs_abort - a0, count);
    endtask

    initial begin
        test_reset();
        test_entry();
        test_exit();
        test_bounce();
        test_saturation();
        test_backout();
        test_async_reset();
        repeat (3) test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
